// File: rtl/irq_capture_ctrl.sv
// Interrupt capture block: synchronises N request lines, captures edges or levels per channel,
// and raises one masked, registered IRQ. Optional 16-bit edge counter under IRQ_CAPTURE_COUNT_EN.
module irq_capture_ctrl #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic [N_CH-1:0] req_in,
  input  logic [2:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  output logic            irq
);

  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_CLEAR  = 3'd2;
  localparam logic [2:0] ADDR_MODE   = 3'd3;
  localparam logic [2:0] ADDR_COUNT  = 3'd4;
  localparam logic [2:0] ADDR_RAW    = 3'd5;

  // The line level that means "not requesting"; the chain resets to it so reset release is quiet.
  localparam logic [N_CH-1:0] LINE_IDLE = {N_CH{ACTIVE_LOW}};

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s_vec;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] pending_q;
  logic [N_CH-1:0] pending_d;
  logic [N_CH-1:0] mask_q;
  logic [N_CH-1:0] mode_q;
  logic [N_CH-1:0] clear_bits;
  logic [N_CH-1:0] wdata_ch;
  logic [31:0]     count_rd;
  logic [31:0]     rd_mux;
  logic            unused_wdata;

  assign unused_wdata = &{1'b0, avs_writedata};
  assign wdata_ch     = avs_writedata[N_CH-1:0];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= LINE_IDLE;
    end else begin
      sync_q[0] <= req_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_vec = ACTIVE_LOW ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
  assign rise  = s_vec & ~prev_q;

  // Edge channels are sticky and a same-cycle edge beats the clear; level channels follow s.
  assign clear_bits = (avs_write && avs_address == ADDR_CLEAR) ? wdata_ch : '0;
  assign pending_d  = (mode_q & (rise | (pending_q & ~clear_bits))) | (~mode_q & s_vec);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      mode_q    <= '1;
      irq       <= 1'b0;
    end else begin
      prev_q    <= s_vec;
      pending_q <= pending_d;
      irq       <= |(pending_q & mask_q);
      if (avs_write && avs_address == ADDR_MASK) mask_q <= wdata_ch;
      if (avs_write && avs_address == ADDR_MODE) mode_q <= wdata_ch;
    end
  end

`ifdef IRQ_CAPTURE_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      count_q <= '0;
    end else if (avs_write && avs_address == ADDR_COUNT) begin
      count_q <= '0;
    end else if (|(rise & mode_q) && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_rd = {16'h0000, count_q};
`else
  assign count_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_STATUS: rd_mux = 32'(pending_q);
      ADDR_MASK:   rd_mux = 32'(mask_q);
      ADDR_MODE:   rd_mux = 32'(mode_q);
      ADDR_COUNT:  rd_mux = count_rd;
      ADDR_RAW:    rd_mux = 32'(s_vec);
      default:     rd_mux = '0;
    endcase
  end

  // Bus: no waitrequest, every strobe is accepted on the edge it is sampled. Read data appears
  // one cycle later and holds until the next read; a same-cycle write is seen by later reads only.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_irq_capture_ctrl.sv
// Bench for irq_capture_ctrl: cycle model of the capture rules checked every cycle,
// plus directed register reads with literal expectations.
module tb_irq_capture_ctrl;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam bit AL = 1'b1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_in;
  logic [2:0]    avs_address;
  logic          avs_read;
  logic          avs_write;
  logic [31:0]   avs_writedata;
  logic [31:0]   avs_readdata;
  logic          irq;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  irq_capture_ctrl #(.N_CH(N), .SYNC_STAGES(SS), .ACTIVE_LOW(AL)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .req_in        (req_in),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  // model: asserted-sample delay line, pending/irq rules, register file
  logic [N-1:0] m_q[$];
  logic [N-1:0] m_s, m_sp, m_pend, m_mask, m_mode;
  logic         m_irq;
  logic [31:0]  m_rd;
  logic [15:0]  m_cnt;

  function automatic logic [31:0] m_reg(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_pend);
      3'd1: return 32'(m_mask);
      3'd3: return 32'(m_mode);
`ifdef IRQ_CAPTURE_COUNT_EN
      3'd4: return {16'h0, m_cnt};
`endif
      3'd5: return 32'(m_s);
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_q = {};
    for (int i = 0; i < SS - 1; i++) m_q.push_back('0);
    m_s = '0; m_sp = '0; m_pend = '0; m_mask = '0; m_mode = '1;
    m_irq = 1'b0; m_rd = '0; m_cnt = '0;
  endtask

  task automatic m_step();
    logic [N-1:0] rise, clr, pend_n, wd;
    wd     = avs_writedata[N-1:0];
    rise   = m_s & ~m_sp;
    clr    = (avs_write && avs_address == 3'd2) ? wd : '0;
    pend_n = (m_mode & (rise | (m_pend & ~clr))) | (~m_mode & m_s);
    if (avs_read) m_rd = m_reg(avs_address);
    if (avs_write && avs_address == 3'd4) m_cnt = '0;
    else if ((rise & m_mode) != '0 && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_irq = ((m_pend & m_mask) != '0);
    if (avs_write && avs_address == 3'd1) m_mask = wd;
    if (avs_write && avs_address == 3'd3) m_mode = wd;
    m_pend = pend_n;
    m_sp   = m_s;
    m_q.push_back(AL ? ~req_in : req_in);
    m_s = m_q.pop_front();
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("irq_vs_model", 32'(irq), 32'(m_irq));
      chk("readdata_vs_model", avs_readdata, m_rd);
    end
  end

  // driver tasks: called at a negedge, return at the negedge after the sampling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus(input logic rd, input logic wr, input logic [2:0] a,
                     input logic [31:0] d, output logic [31:0] q);
    avs_read = rd; avs_write = wr; avs_address = a; avs_writedata = d;
    tick();
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    q = avs_readdata;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] q;
    bus(1'b0, 1'b1, a, d, q);
  endtask

  task automatic rd_expect(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] q;
    exp_q.push_back(exp);
    bus(1'b1, 1'b0, a, 32'h0, q);
    chk(name, q, exp_q.pop_front());
  endtask

  task automatic pulse(input logic [N-1:0] v);
    req_in = v;
    tick();
    req_in = '1;
    repeat (3) tick();
  endtask

  logic [31:0] rst_exp [8] = '{32'h0, 32'h0, 32'h0, 32'hF, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] q;

  initial begin
    req_in = '1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    chk("irq_during_reset", 32'(irq), 32'h0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    tick();

    for (int a = 0; a < 8; a++) rd_expect($sformatf("reset_read_addr%0d", a), 3'(a), rst_exp[a]);
    chk("irq_after_reset", 32'(irq), 32'h0);

    // edge capture latency and clear on channel 0
    bus_wr(3'd1, 32'h1);
    req_in[0] = 1'b0;
    repeat (3) tick();
    chk("irq_before_latency", 32'(irq), 32'h0);
    tick();
    chk("irq_at_latency", 32'(irq), 32'h1);
    req_in[0] = 1'b1;
    repeat (3) tick();
    rd_expect("status_sticky_ch0", 3'd0, 32'h1);
    bus_wr(3'd2, 32'h1);
    chk("irq_same_cycle_as_clear", 32'(irq), 32'h1);
    tick();
    chk("irq_after_clear", 32'(irq), 32'h0);
    rd_expect("status_after_clear", 3'd0, 32'h0);

    // masked capture on channel 2, then unmask
    bus_wr(3'd1, 32'h0);
    pulse(4'hB);
    repeat (2) tick();
    rd_expect("status_masked_ch2", 3'd0, 32'h4);
    chk("irq_masked_ch2", 32'(irq), 32'h0);
    bus_wr(3'd1, 32'h4);
    tick();
    chk("irq_after_unmask", 32'(irq), 32'h1);
    bus_wr(3'd2, 32'h4);
    tick();
    chk("irq_after_clear_ch2", 32'(irq), 32'h0);
    bus_wr(3'd1, 32'h0);

    // level mode on channel 0: clear ignored, release drops irq
    bus_wr(3'd3, 32'hE);
    bus_wr(3'd1, 32'h1);
    req_in[0] = 1'b0;
    repeat (5) tick();
    chk("irq_level_held", 32'(irq), 32'h1);
    bus_wr(3'd2, 32'h1);
    repeat (2) tick();
    chk("irq_level_clear_ignored", 32'(irq), 32'h1);
    rd_expect("raw_level_held", 3'd5, 32'h1);
    req_in[0] = 1'b1;
    repeat (SS + 2) tick();
    chk("irq_level_released", 32'(irq), 32'h0);

    // level -> edge switch keeps the pending bit and makes it sticky
    req_in[0] = 1'b0;
    repeat (4) tick();
    bus_wr(3'd3, 32'hF);
    req_in[0] = 1'b1;
    repeat (4) tick();
    rd_expect("status_kept_after_mode_switch", 3'd0, 32'h1);
    bus_wr(3'd2, 32'h1);
    rd_expect("status_cleared_after_switch", 3'd0, 32'h0);
    bus_wr(3'd1, 32'h0);

    // edge and clear on channel 1 in the same cycle: edge wins
    req_in = 4'hD;
    tick();
    tick();
    bus_wr(3'd2, 32'h2);
    rd_expect("status_edge_beats_clear", 3'd0, 32'h2);
    req_in = '1;
    tick();
    bus_wr(3'd2, 32'h2);
    rd_expect("status_ch1_cleared", 3'd0, 32'h0);

    // read and write of MASK in the same cycle returns the old value
    bus(1'b1, 1'b1, 3'd1, 32'h3, q);
    chk("rw_same_cycle_old_value", q, 32'h0);
    rd_expect("mask_new_value", 3'd1, 32'h3);
    rd_expect("mask_upper_bits_ignored", 3'd1, 32'h3);
    bus_wr(3'd1, 32'hFFFF_FFF0);
    rd_expect("mask_write_upper_only", 3'd1, 32'h0);

    // reset mid-operation with the line held asserted through release
    bus_wr(3'd1, 32'h1);
    rd_expect("mode_before_reset", 3'd3, 32'hF);
    req_in[0] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("irq_async_reset", 32'(irq), 32'h0);
    chk("readdata_async_reset", avs_readdata, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus_wr(3'd1, 32'h1);
    repeat (5) tick();
    rd_expect("status_held_across_reset", 3'd0, 32'h1);
    chk("irq_held_across_reset", 32'(irq), 32'h1);
    bus_wr(3'd2, 32'h1);
    repeat (4) tick();
    rd_expect("status_single_edge", 3'd0, 32'h0);
    chk("irq_single_edge", 32'(irq), 32'h0);
    req_in[0] = 1'b1;
    bus_wr(3'd1, 32'h0);
    repeat (3) tick();

`ifdef IRQ_CAPTURE_COUNT_EN
    bus_wr(3'd4, 32'h0);
    pulse(4'h6);
    pulse(4'hD);
    pulse(4'hB);
    pulse(4'hE);
    rd_expect("count_four_cycles", 3'd4, 32'h4);
    for (int i = 0; i < 65540; i++) begin
      req_in = (i % 2 == 0) ? 4'hE : 4'hD;
      tick();
    end
    req_in = '1;
    repeat (4) tick();
    rd_expect("count_saturated", 3'd4, 32'hFFFF);
    bus_wr(3'd4, 32'h0);
    rd_expect("count_cleared", 3'd4, 32'h0);
`else
    pulse(4'h6);
    rd_expect("count_absent_reads_zero", 3'd4, 32'h0);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
